qbu_rx_arbiter: RTL
===================

# qbu_rx_arbiter

Frame-atomic arbiter for the 802.3br (Qbu) receive path. It merges the express-MAC (eMAC) receive buffer output and the preemptable-MAC (pMAC) reassembly output into a single AXI-stream toward the switch core. eMAC has strict priority at frame boundaries, and a starvation guard guarantees pMAC forward progress. A single output register stage gives full throughput inside a frame.

## Interface
- DWIDTH, 8, data width in bits; keep width is DWIDTH/8
- STARVE_LIMIT, 4, consecutive eMAC grants tolerated while pMAC is waiting; range 1..255
- i_clk  in  1  clock
- i_rst  in  1  reset, asynchronous, active-high
- i_emac_data / i_emac_user / i_emac_keep  in  DWIDTH / 16 / DWIDTH/8  eMAC beat
- i_emac_last / i_emac_valid  in  1 / 1  eMAC frame end / beat valid
- o_emac_ready  out  1  eMAC accept
- i_emac_no_empty  in  1  eMAC buffer holds a pending or in-flight frame (early request)
- i_pmac_data / i_pmac_user / i_pmac_keep / i_pmac_last / i_pmac_valid  in  as eMAC  pMAC beat
- o_pmac_ready  out  1  pMAC accept
- o_data / o_user / o_keep / o_last / o_valid  out  as inputs  merged stream
- o_src  out  1  source of the current output beat: 0 = eMAC, 1 = pMAC
- i_ready  in  1  downstream accept
- o_emac_frm_cnt / o_pmac_frm_cnt  out  16 / 16  frames forwarded per source, wrapping
- o_busy  out  1  state is not IDLE

## Operation
- FSM states: IDLE, EMAC, PMAC.
- eMAC request: `e_req = i_emac_valid | i_emac_no_empty`. pMAC request: `p_req = i_pmac_valid`.
- Transitions out of IDLE:
  - If p_req and starve_cnt == STARVE_LIMIT: go to PMAC.
  - Else if e_req: go to EMAC.
  - Else if p_req: go to PMAC.
  - Else stay in IDLE.
- starve_cnt (8 bits):
  - On entry to EMAC: +1 if p_req, else cleared.
  - On entry to PMAC: cleared.
  - Saturates at STARVE_LIMIT.
- Source ready: `o_X_ready = (state == X) & (!o_valid | i_ready)`. Ready for the non-granted source is always 0.
- Accept = source valid & source ready. On accept, the beat is loaded into the output register and o_src is set.
- Leaving a grant state:
  - EMAC/PMAC → IDLE in the cycle after an accept with last = 1.
  - EMAC → IDLE if no beat of the frame has yet been accepted and both i_emac_valid and i_emac_no_empty are low. This covers a spurious early request.
- A granted frame is never interrupted, whatever the other source does.
- Output register:
  - o_valid sets on accept.
  - o_valid clears when `o_valid & i_ready` occurs with no simultaneous accept.
  - All output fields hold while `o_valid & !i_ready`.
- Frame counters: +1 when an output beat with o_last = 1 is taken (`o_valid & i_ready & o_last`), selected by o_src. Counters wrap 0xFFFF → 0.
- User and keep pass through unmodified. Keep is not checked against last.

## Timing
- Reset: state IDLE. All outputs are 0: o_valid, o_last, o_data, o_user, o_keep, o_src, both readies, both counters, o_busy. starve_cnt is 0.
- Reset asserted mid-frame discards the in-flight beat. The partial frame is not completed.
- Grant latency: a request sampled in IDLE at cycle t gives state X and source ready at t+1. The first beat is accepted at t+1 and appears on o_valid at t+2.
- Inside a frame, with i_ready held high: one beat per cycle, no bubbles.
- Between frames: last accepted at t, IDLE at t+1, next grant at t+2. This leaves exactly one output bubble cycle (at t+2 with continuous ready).
- Backpressure: `i_ready = 0` with o_valid = 1 drops the source ready in the same cycle (combinational). No beat is lost or duplicated.
- Simultaneous eMAC and pMAC requests in IDLE: eMAC wins unless the starvation limit has been reached.
- o_busy is registered from the state and aligned with it.

## Test plan
- eMAC-only traffic: 64-beat frame, user = 64, i_ready = 1. Expect o_valid 2 cycles after i_emac_valid, 64 contiguous beats, o_last on beat 64, o_src = 0, o_emac_frm_cnt = 1.
- Simultaneous requests: both sources valid in IDLE with STARVE_LIMIT = 4.
  - Expect the eMAC frame first, then the pMAC frame.
  - o_pmac_ready stays 0 for the whole eMAC frame, including while pMAC valid is high.
- Starvation: the pMAC request is held and eMAC presents 6 back-to-back frames. Expect grant order E, E, E, E, P, E, E (pMAC granted after the 4th eMAC frame).
- Backpressure: i_ready toggles 1010… during a 16-beat pMAC frame. Expect all 16 beats with byte-exact data, each held stable while not ready, and 16 accepts on the pMAC input.
- Early request: i_emac_no_empty pulses for 1 cycle with no valid, while pMAC is valid.
  - Expect EMAC to be entered, then the return to IDLE 1 cycle after the request drops.
  - Expect the pMAC grant on the next decision, with no output beat from eMAC.
- Reset mid-frame: i_rst asserted at beat 10 of 20. Expect all outputs 0 immediately and state IDLE. Expect the next frame to be forwarded normally with counters restarted from 0.

Source files
------------

// File: rtl/qbu_rx_arbiter.sv
// ---------------------------------------------------------------------------
// qbu_rx_arbiter
//
// Frame-atomic arbiter for the 802.3br receive path. Merges the express MAC
// (eMAC) receive buffer stream and the preemptable MAC (pMAC) reassembly
// stream into one AXI-stream toward the switch core.
//
// eMAC has strict priority at frame boundaries. A starvation counter makes
// sure pMAC is granted after STARVE_LIMIT consecutive eMAC grants taken while
// pMAC was waiting. One output register stage gives one beat per cycle
// inside a frame.
//
// Ports
//   i_clk, i_rst                       clock, asynchronous active-high reset
//   i_emac_* / o_emac_ready            eMAC beat (data/user/keep/last/valid)
//   i_emac_no_empty                    eMAC buffer has a frame (early request)
//   i_pmac_* / o_pmac_ready            pMAC beat (data/user/keep/last/valid)
//   o_data/o_user/o_keep/o_last/o_valid merged output beat
//   o_src                              0 = eMAC beat, 1 = pMAC beat
//   i_ready                            downstream accept
//   o_emac_frm_cnt / o_pmac_frm_cnt    frames forwarded per source (wrapping)
//   o_busy                             arbiter is not idle
// ---------------------------------------------------------------------------
module qbu_rx_arbiter #(
    parameter int DWIDTH       = 8,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [DWIDTH-1:0]     i_emac_data,
    input  logic [15:0]           i_emac_user,
    input  logic [DWIDTH/8-1:0]   i_emac_keep,
    input  logic                  i_emac_last,
    input  logic                  i_emac_valid,
    output logic                  o_emac_ready,
    input  logic                  i_emac_no_empty,
    input  logic [DWIDTH-1:0]     i_pmac_data,
    input  logic [15:0]           i_pmac_user,
    input  logic [DWIDTH/8-1:0]   i_pmac_keep,
    input  logic                  i_pmac_last,
    input  logic                  i_pmac_valid,
    output logic                  o_pmac_ready,
    output logic [DWIDTH-1:0]     o_data,
    output logic [15:0]           o_user,
    output logic [DWIDTH/8-1:0]   o_keep,
    output logic                  o_last,
    output logic                  o_valid,
    output logic                  o_src,
    input  logic                  i_ready,
    output logic [15:0]           o_emac_frm_cnt,
    output logic [15:0]           o_pmac_frm_cnt,
    output logic                  o_busy
);

    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    typedef enum logic [1:0] {IDLE, EMAC, PMAC} state_t;

    state_t               state_q, state_d;
    logic [7:0]           starve_q, starve_d;
    logic                 seen_q, seen_d;
    logic                 busy_q;

    logic [DWIDTH-1:0]    data_q;
    logic [15:0]          user_q;
    logic [DWIDTH/8-1:0]  keep_q;
    logic                 last_q;
    logic                 valid_q;
    logic                 src_q;
    logic [15:0]          ecnt_q;
    logic [15:0]          pcnt_q;

    logic e_req, p_req, out_free;
    logic emac_acc, pmac_acc, accept;

    assign e_req    = i_emac_valid | i_emac_no_empty;
    assign p_req    = i_pmac_valid;

    // The output register can take a new beat when it is empty or being
    // drained this cycle; this is what makes backpressure combinational.
    assign out_free     = !valid_q | i_ready;
    assign o_emac_ready = (state_q == EMAC) & out_free;
    assign o_pmac_ready = (state_q == PMAC) & out_free;

    assign emac_acc = i_emac_valid & o_emac_ready;
    assign pmac_acc = i_pmac_valid & o_pmac_ready;
    assign accept   = emac_acc | pmac_acc;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= IDLE;
            starve_q <= 8'd0;
            seen_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            seen_q   <= seen_d;
            busy_q   <= (state_d != IDLE);
        end
    end

    // seen tracks whether any beat of the granted eMAC frame was taken; an
    // eMAC grant that never saw a beat is released once the early request
    // (no_empty) and valid both go away.
    always_comb begin
        state_d  = state_q;
        starve_d = starve_q;
        seen_d   = seen_q;
        case (state_q)
            IDLE: begin
                seen_d = 1'b0;
                if (p_req && (starve_q == LIMIT)) begin
                    state_d  = PMAC;
                    starve_d = 8'd0;
                end else if (e_req) begin
                    state_d = EMAC;
                    if (p_req)
                        starve_d = (starve_q < LIMIT) ? starve_q + 8'd1 : LIMIT;
                    else
                        starve_d = 8'd0;
                end else if (p_req) begin
                    state_d  = PMAC;
                    starve_d = 8'd0;
                end
            end
            EMAC: begin
                if (emac_acc)
                    seen_d = 1'b1;
                if (emac_acc && i_emac_last)
                    state_d = IDLE;
                else if (!seen_q && !i_emac_valid && !i_emac_no_empty)
                    state_d = IDLE;
            end
            PMAC: begin
                if (pmac_acc && i_pmac_last)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Output beat register: loads on accept, otherwise drains on i_ready and
    // holds every field while stalled.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            data_q  <= '0;
            user_q  <= '0;
            keep_q  <= '0;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
            src_q   <= 1'b0;
        end else if (accept) begin
            data_q  <= pmac_acc ? i_pmac_data : i_emac_data;
            user_q  <= pmac_acc ? i_pmac_user : i_emac_user;
            keep_q  <= pmac_acc ? i_pmac_keep : i_emac_keep;
            last_q  <= pmac_acc ? i_pmac_last : i_emac_last;
            src_q   <= pmac_acc;
            valid_q <= 1'b1;
        end else if (valid_q && i_ready) begin
            valid_q <= 1'b0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ecnt_q <= 16'd0;
            pcnt_q <= 16'd0;
        end else if (valid_q && i_ready && last_q) begin
            if (src_q)
                pcnt_q <= pcnt_q + 16'd1;
            else
                ecnt_q <= ecnt_q + 16'd1;
        end
    end

    assign o_data         = data_q;
    assign o_user         = user_q;
    assign o_keep         = keep_q;
    assign o_last         = last_q;
    assign o_valid        = valid_q;
    assign o_src          = src_q;
    assign o_emac_frm_cnt = ecnt_q;
    assign o_pmac_frm_cnt = pcnt_q;
    assign o_busy         = busy_q;

endmodule
